// File: rtl/despachante_pedidos.sv
// Coffee order dispatcher.
// Buffers incoming orders and hands them to a downstream coffee machine one
// at a time. Each handoff is a single start pulse, after which the dispatcher
// follows the machine through its brewing cycle and counts completed coffees.
module despachante_pedidos #(
    parameter int         PROFUNDIDADE = 4,
    parameter logic [3:0] IDLE_CODE    = 4'd1,
    parameter int         TIMEOUT      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pedido,
    input  logic [3:0] machine_state,
    output logic       start,
    output logic [2:0] pendentes,
    output logic       cheio,
    output logic       descartado,
    output logic       ocupado,
    output logic       erro,
    output logic [7:0] cafes_prontos
);

    // The timer only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
    localparam int             TW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]     DEPTH      = 3'(PROFUNDIDADE);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        DISPARO = 2'd1,
        SAIDA   = 2'd2,
        CICLO   = 2'd3
    } estado_t;

    estado_t       state;
    logic [TW-1:0] timer;
    logic          machine_idle;
    logic          dispatching;

    assign machine_idle = (machine_state == IDLE_CODE);
    assign dispatching  = (state == DISPARO);

    // Status flags are plain decodes of registered state.
    assign cheio   = (pendentes == DEPTH);
    assign ocupado = (state != ESPERA);

    // Order counter: an order arriving while one is dispatched cancels out,
    // so a full queue never drops an order in the DISPARO cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pendentes  <= 3'd0;
            descartado <= 1'b0;
        end else begin
            descartado <= 1'b0;
            if (pedido && !dispatching) begin
                if (cheio) begin
                    descartado <= 1'b1;
                end else begin
                    pendentes <= pendentes + 3'd1;
                end
            end else if (!pedido && dispatching) begin
                pendentes <= pendentes - 3'd1;
            end
        end
    end

    // Dispatch FSM: fire one start pulse, wait for the machine to leave idle
    // (or give up after TIMEOUT cycles), then wait for it to return to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ESPERA;
            start         <= 1'b0;
            erro          <= 1'b0;
            cafes_prontos <= 8'd0;
            timer         <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                ESPERA: begin
                    if ((pendentes != 3'd0) && machine_idle) begin
                        state <= DISPARO;
                        start <= 1'b1;
                    end
                end
                DISPARO: begin
                    state <= SAIDA;
                    timer <= '0;
                end
                SAIDA: begin
                    if (!machine_idle) begin
                        state <= CICLO;
                    end else if (timer == TIMER_LAST) begin
                        erro  <= 1'b1;
                        state <= ESPERA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CICLO: begin
                    if (machine_idle) begin
                        state <= ESPERA;
                        if (cafes_prontos != 8'hFF) begin
                            cafes_prontos <= cafes_prontos + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ESPERA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_despachante_pedidos.sv
// Directed testbench for despachante_pedidos.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check sees the state produced by the preceding edge.
module tb_despachante_pedidos;

    logic       clk;
    logic       rst;
    logic       pedido;
    logic [3:0] machine_state;
    logic       start;
    logic [2:0] pendentes;
    logic       cheio;
    logic       descartado;
    logic       ocupado;
    logic       erro;
    logic [7:0] cafes_prontos;

    int numCompared;
    int numMismatched;

    despachante_pedidos #(
        .PROFUNDIDADE(4),
        .IDLE_CODE(4'd1),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pedido(pedido),
        .machine_state(machine_state),
        .start(start),
        .pendentes(pendentes),
        .cheio(cheio),
        .descartado(descartado),
        .ocupado(ocupado),
        .erro(erro),
        .cafes_prontos(cafes_prontos)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input int got, input int expected);
        numCompared++;
        if (got != expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
        end
    endtask

    // Advance one clock edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and advance past the next edge.
    task automatic applyStimulus(input logic p, input logic [3:0] ms);
        pedido        = p;
        machine_state = ms;
        tick();
    endtask

    task automatic doReset();
        rst    = 1'b1;
        pedido = 1'b0;
        machine_state = 4'd1;
        tick();
        rst = 1'b0;
    endtask

    // One complete order: register, dispatch, leave idle, return to idle.
    task automatic doCoffee();
        applyStimulus(1'b1, 4'd1);
        applyStimulus(1'b0, 4'd1);
        applyStimulus(1'b0, 4'd2);
        applyStimulus(1'b0, 4'd2);
        applyStimulus(1'b0, 4'd1);
    endtask

    initial begin
        int drops;
        int starts;
        int lastStart;
        int busy;

        numCompared   = 0;
        numMismatched = 0;

        // Reset with pedido held high: the order must be ignored.
        rst = 1'b1;
        pedido = 1'b1;
        machine_state = 4'd1;
        tick();
        tick();
        checkOutput("reset_pendentes", pendentes, 0);
        checkOutput("reset_start", start, 0);
        checkOutput("reset_ocupado", ocupado, 0);
        checkOutput("reset_cheio", cheio, 0);
        checkOutput("reset_descartado", descartado, 0);
        checkOutput("reset_erro", erro, 0);
        checkOutput("reset_cafes", cafes_prontos, 0);
        rst = 1'b0;

        // Single order: start exactly two edges after the pedido cycle.
        applyStimulus(1'b1, 4'd1);
        checkOutput("single_pend_visible", pendentes, 1);
        checkOutput("single_no_early_start", start, 0);
        applyStimulus(1'b0, 4'd1);
        checkOutput("single_start", start, 1);
        checkOutput("single_pend_in_disparo", pendentes, 1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 4'(2 + (k % 7)));
            if (k == 0) begin
                checkOutput("single_start_one_cycle", start, 0);
                checkOutput("single_pend_after", pendentes, 0);
            end
        end
        checkOutput("single_ocupado_in_ciclo", ocupado, 1);
        applyStimulus(1'b0, 4'd1);
        checkOutput("single_cafes", cafes_prontos, 1);
        checkOutput("single_ocupado_done", ocupado, 0);
        checkOutput("single_pend_done", pendentes, 0);

        // Burst of 6 while machine is busy: 4 kept, 2 dropped.
        doReset();
        drops = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 4'd3);
            if (descartado) drops++;
            if (k == 3) checkOutput("burst_cheio_at4", cheio, 1);
        end
        applyStimulus(1'b0, 4'd3);
        if (descartado) drops++;
        checkOutput("burst_drops", drops, 2);
        checkOutput("burst_pend", pendentes, 4);
        checkOutput("burst_cheio", cheio, 1);
        checkOutput("burst_no_start_busy", start, 0);
        applyStimulus(1'b0, 4'd1);
        checkOutput("burst_start", start, 1);
        applyStimulus(1'b0, 4'd1);
        checkOutput("burst_pend_after", pendentes, 3);
        checkOutput("burst_cheio_after", cheio, 0);

        // Full queue with pedido in the DISPARO cycle: no change, no drop.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 4'd3);
        applyStimulus(1'b0, 4'd1);
        checkOutput("full_disp_start", start, 1);
        applyStimulus(1'b1, 4'd1);
        checkOutput("full_disp_pend", pendentes, 4);
        checkOutput("full_disp_descartado", descartado, 0);
        pedido = 1'b0;

        // Back-to-back: bench-modelled machine busy for 4 cycles after start.
        doReset();
        starts = 0;
        lastStart = -1;
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i < 3, (busy > 0) ? 4'd2 : 4'd1);
            if (busy > 0) busy--;
            if (start) begin
                if (starts == 0) checkOutput("b2b_first_start", i, 1);
                else checkOutput("b2b_gap", i - lastStart, 6);
                starts++;
                lastStart = i;
                busy = 4;
            end
        end
        checkOutput("b2b_starts", starts, 3);
        checkOutput("b2b_cafes", cafes_prontos, 3);
        checkOutput("b2b_pend", pendentes, 0);
        checkOutput("b2b_ocupado", ocupado, 0);

        // Timeout: machine never leaves idle.
        doReset();
        applyStimulus(1'b1, 4'd1);
        applyStimulus(1'b0, 4'd1);
        checkOutput("to_start", start, 1);
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 4'd1);
        checkOutput("to_erro_not_yet", erro, 0);
        checkOutput("to_still_saida", ocupado, 1);
        applyStimulus(1'b0, 4'd1);
        checkOutput("to_erro", erro, 1);
        checkOutput("to_espera", ocupado, 0);
        checkOutput("to_pend", pendentes, 0);
        starts = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 4'd1);
            if (start) starts++;
        end
        checkOutput("to_no_second_start", starts, 0);
        checkOutput("to_erro_sticky", erro, 1);
        applyStimulus(1'b1, 4'd1);
        applyStimulus(1'b0, 4'd1);
        checkOutput("to_erro_no_block", start, 1);

        // Reset mid-CICLO with two pending orders.
        doReset();
        applyStimulus(1'b1, 4'd1);
        applyStimulus(1'b0, 4'd1);
        applyStimulus(1'b0, 4'd2);
        applyStimulus(1'b0, 4'd2);
        applyStimulus(1'b1, 4'd2);
        applyStimulus(1'b1, 4'd2);
        checkOutput("rmid_pend_before", pendentes, 2);
        checkOutput("rmid_ocupado_before", ocupado, 1);
        rst = 1'b1;
        applyStimulus(1'b0, 4'd1);
        rst = 1'b0;
        checkOutput("rmid_pend", pendentes, 0);
        checkOutput("rmid_ocupado", ocupado, 0);
        checkOutput("rmid_start", start, 0);
        checkOutput("rmid_cafes", cafes_prontos, 0);
        checkOutput("rmid_erro", erro, 0);
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 4'd1);
            if (start) starts++;
        end
        checkOutput("rmid_no_start", starts, 0);

        // Saturation of the coffee counter at 255.
        doReset();
        for (int k = 0; k < 255; k++) doCoffee();
        checkOutput("sat_255", cafes_prontos, 255);
        doCoffee();
        checkOutput("sat_hold", cafes_prontos, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/despachante_pedidos.md
DESPACHANTE_PEDIDOS -- requirements
Module: despachante_pedidos

Interface
REQ-001 Parameter PROFUNDIDADE, default 4, maximum number of buffered coffee orders (1..7).
REQ-002 Parameter IDLE_CODE, default 4'd1, value of machine_state that denotes the coffee machine IDLE state.
REQ-003 Parameter TIMEOUT, default 16, cycles allowed for the machine to leave IDLE after start.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pedido  input  1  order request; each cycle high = one order.
REQ-007 machine_state  input  4  current state of the downstream coffee machine.
REQ-008 start  output  1  one-cycle start pulse to the coffee machine.
REQ-009 pendentes  output  3  number of buffered, not-yet-dispatched orders.
REQ-010 cheio  output  1  high when pendentes == PROFUNDIDADE.
REQ-011 descartado  output  1  one-cycle pulse: an order was dropped because the queue was full.
REQ-012 ocupado  output  1  high whenever the FSM is not in ESPERA.
REQ-013 erro  output  1  sticky timeout flag.
REQ-014 cafes_prontos  output  8  count of completed coffee cycles.

Function
REQ-015 The FSM SHALL have four states: ESPERA, DISPARO, SAIDA and CICLO.
REQ-016 ESPERA -> DISPARO when pendentes > 0 and machine_state == IDLE_CODE; otherwise the FSM stays in ESPERA.
REQ-017 In DISPARO, start SHALL be 1 for exactly that cycle, pendentes SHALL decrement by 1, and the FSM SHALL go to SAIDA.
REQ-018 Outside DISPARO, start SHALL be 0.
REQ-019 SAIDA -> CICLO on the first cycle with machine_state != IDLE_CODE.
REQ-020 In SAIDA, an internal counter SHALL count cycles; after TIMEOUT cycles still at IDLE_CODE, erro SHALL be set to 1 and the FSM SHALL return to ESPERA, losing the dispatched order.
REQ-021 The timeout counter SHALL clear on entry to SAIDA.
REQ-022 CICLO -> ESPERA on the first cycle with machine_state == IDLE_CODE.
REQ-023 On the CICLO -> ESPERA transition, cafes_prontos SHALL increment, saturating at 255.
REQ-024 A pedido accepted in cycle N SHALL be visible in pendentes in cycle N+1.
REQ-025 The earliest start SHALL occur 2 cycles after pedido if the machine is IDLE: one cycle to register the order, one in ESPERA.
REQ-026 pedido while full with no simultaneous decrement: the order SHALL NOT be counted, and descartado SHALL be 1 for the next cycle.
REQ-027 pedido in the same cycle as the DISPARO decrement: pendentes SHALL be unchanged, with no drop even if full.
REQ-028 pedido SHALL be accepted in every FSM state.
REQ-029 erro SHALL remain 1 until rst and SHALL NOT block further dispatching.
REQ-030 erro is only a status output; it SHALL NOT gate any logic.
REQ-031 cheio, ocupado, pendentes, erro and cafes_prontos SHALL be registered outputs or direct decodes of registers.

Reset
REQ-032 While rst = 1 at a clock edge: state = ESPERA, start = 0, pendentes = 0, cheio = 0, descartado = 0, erro = 0, cafes_prontos = 0, timeout counter = 0.
REQ-033 Reset mid-operation, in any state, SHALL discard all pending orders with no start pulse on the following cycle.
REQ-034 pedido asserted during rst SHALL be ignored.

Verification
REQ-035 Single order: pedido for 1 cycle, machine_state = 1 -> start = 1 exactly 2 cycles later; then machine_state 2..8 for 10 cycles, back to 1 -> cafes_prontos = 1, ocupado = 0, pendentes = 0.
REQ-036 Burst: 6 consecutive pedido cycles while machine_state = 3 (busy) -> pendentes = 4, cheio = 1, descartado pulses twice; when the machine returns to 1, start follows and pendentes = 3.
REQ-037 Back-to-back: 3 orders, machine cycling 1 -> 2 -> 1 -> ... -> exactly 3 start pulses, each separated by a full CICLO, cafes_prontos = 3.
REQ-038 Timeout: 1 order, machine_state held at 1 forever -> start once, erro = 1 after TIMEOUT = 16 cycles in SAIDA, FSM in ESPERA, pendentes = 0, no second start.
REQ-039 Reset mid-CICLO with pendentes = 2 -> all outputs 0 next cycle; machine_state = 1 afterwards with no pedido -> start stays 0 for 5 cycles.
REQ-040 Full plus simultaneous dispatch: pendentes = 4, pedido in the DISPARO cycle -> pendentes stays 4, descartado = 0.
